umi_regif_arb: RTL and testbench
================================

UMI_REGIF_ARB -- requirements
Module: umi_regif_arb

Interface
REQ-001 SHALL have parameters: N, 4, number of UMI requesters (2..16); UW, 256, packet width; DEPTH, 4, outstanding-read tag FIFO depth (power of 2, >=2).
REQ-002 SHALL have ports: clk  in  1  clock.
REQ-003 SHALL have ports: nreset  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports: host_req_valid  in  N  per-requester request valid.
REQ-005 SHALL have ports: host_req_packet  in  N*UW  requester i packet at [i*UW+:UW].
REQ-006 SHALL have ports: host_req_ready  out  N  per-requester accept.
REQ-007 SHALL have ports: host_resp_valid  out  N  per-requester response valid.
REQ-008 SHALL have ports: host_resp_packet  out  UW  response packet, broadcast to all requesters.
REQ-009 SHALL have ports: host_resp_ready  in  N  per-requester response ready.
REQ-010 SHALL have ports: udev_req_valid / udev_req_packet / udev_req_ready  out / out UW / in  shared register-interface request port.
REQ-011 SHALL have ports: udev_resp_valid / udev_resp_packet / udev_resp_ready  in / in UW / out  shared register-interface response port.
REQ-012 SHALL have ports: outstanding  out  $clog2(DEPTH)+1  reads in flight; err_orphan  out  1  sticky, response seen with no read in flight.

Function
REQ-013 SHALL arbitrate round-robin: search starts at pointer ptr, first set host_req_valid bit at or after ptr (wrapping) wins.
REQ-014 SHALL classify request as read iff its command field (packet[7:0]) decodes as non-write (same decode as umi_write); writes expect no response.
REQ-015 SHALL lock the grant while udev_req_valid=1 and udev_req_ready=0; the locked requester and packet stay presented unchanged.
REQ-016 SHALL drive udev_req_valid = winner valid AND NOT(winner is read AND tag FIFO full); udev_req_packet = winner packet; zero added latency.
REQ-017 SHALL assert host_req_ready[i] only for the winner i, equal to udev_req_ready AND udev_req_valid; all others 0.
REQ-018 SHALL on request handshake set ptr = winner+1 (mod N) and release the lock.
REQ-019 SHALL on read handshake push winner index into tag FIFO; full FIFO blocks reads even if a pop occurs the same cycle; writes from other requesters MAY still win while a blocked read holds no lock.
REQ-020 SHALL, when FIFO non-empty, route host_resp_valid[head]=udev_resp_valid, udev_resp_ready=host_resp_ready[head], host_resp_packet=udev_resp_packet.
REQ-021 SHALL pop FIFO on response handshake; simultaneous push and pop leave outstanding unchanged.
REQ-022 SHALL, when FIFO empty, drive udev_resp_ready=1, all host_resp_valid=0, drop the response, and set err_orphan if udev_resp_valid=1.
REQ-023 SHALL keep outstanding equal to FIFO occupancy, range 0..DEPTH.

Reset
REQ-024 SHALL on nreset=0 at a clk edge: ptr=0, lock clear, FIFO empty, outstanding=0, err_orphan=0.
REQ-025 SHALL hold udev_req_valid, host_req_ready, host_resp_valid at 0 and udev_resp_ready at 1 during reset; in-flight reads at reset are discarded and their responses afterwards are orphans.

Structure
REQ-026 SHALL take the command field offset and read/write decode from the shared UMI messages package; no local opcode constants.
REQ-027 SHALL implement the tag FIFO as sub-module umi_regif_arb_tagfifo (width $clog2(N), depth DEPTH, push/pop/full/empty/count).
REQ-028 SHALL keep RTL within 120-400 lines.

Verification
REQ-029 SHALL cover: N=4, all valid writes, udev_req_ready=1 -> grants 0,1,2,3,0 on consecutive cycles.
REQ-030 SHALL cover: requester 2 read, udev_req_ready low 3 cycles, requester 0 asserts -> grant stays 2, packet stable, requester 0 served next.
REQ-031 SHALL cover: DEPTH=4, 5 reads, no responses -> 4 accepted, outstanding=4, fifth stalls; one response -> fifth accepted next cycle.
REQ-032 SHALL cover: reads from 3 then 1 -> first response host_resp_valid=4'b1000, second 4'b0010; host_resp_ready[3]=0 stalls udev_resp_ready.
REQ-033 SHALL cover: udev_resp_valid with FIFO empty -> udev_resp_ready=1, no host_resp_valid, err_orphan=1 until reset.
REQ-034 SHALL cover: nreset low with outstanding=2 -> outstanding=0, ptr=0 next cycle; later response flagged orphan.

Source files
------------

// File: rtl/umi_regif_arb_pkg.sv
// umi_regif_arb_pkg: UMI command field location and request-type decode shared by the arbiter
package umi_regif_arb_pkg;
  localparam int UMI_CMD_LSB = 0;
  localparam int UMI_OPC_W = 5;
  typedef enum logic [UMI_OPC_W-1:0] {
    UMI_INVALID    = 5'h00,
    UMI_REQ_READ   = 5'h01,
    UMI_REQ_WRITE  = 5'h03,
    UMI_REQ_POSTED = 5'h05,
    UMI_REQ_RDMA   = 5'h07,
    UMI_REQ_ATOMIC = 5'h09
  } umi_opcode_e;
  function automatic logic umi_write(input logic [UMI_OPC_W-1:0] opcode);
    return opcode inside {UMI_REQ_WRITE, UMI_REQ_POSTED, UMI_REQ_RDMA};
  endfunction
endpackage

// File: rtl/umi_regif_arb_tagfifo.sv
// umi_regif_arb_tagfifo: requester-index FIFO recording the order of reads in flight
module umi_regif_arb_tagfifo #(
  parameter int W = 2,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [W-1:0]           head
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  always_comb begin
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (!nreset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
    if (push) mem_q[wr_q] <= push_data;
  end
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign head = mem_q[rd_q];
endmodule

// File: rtl/umi_regif_arb.sv
// umi_regif_arb: round-robin arbiter from N UMI hosts onto one register interface; a tag FIFO routes read responses back
module umi_regif_arb
  import umi_regif_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int UW = 256,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic [N-1:0]           host_req_valid,
  input  logic [N*UW-1:0]        host_req_packet,
  output logic [N-1:0]           host_req_ready,
  output logic [N-1:0]           host_resp_valid,
  output logic [UW-1:0]          host_resp_packet,
  input  logic [N-1:0]           host_resp_ready,
  output logic                   udev_req_valid,
  output logic [UW-1:0]          udev_req_packet,
  input  logic                   udev_req_ready,
  input  logic                   udev_resp_valid,
  input  logic [UW-1:0]          udev_resp_packet,
  output logic                   udev_resp_ready,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic                   err_orphan
);
  localparam int IW = $clog2(N);
  logic [UW-1:0] pkt [N];
  logic [N-1:0] rot;
  logic [IW-1:0] ptr_q, ptr_d, lidx_q, lidx_d, win, off, head;
  logic [IW:0] sum;
  logic lock_q, lock_d, orphan_q, orphan_d, win_rd, hs, full, empty, push, pop;
  for (genvar i = 0; i < N; i++) begin : g_pkt
    assign pkt[i] = host_req_packet[i*UW +: UW];
  end
  always_comb begin
    rot = N'({host_req_valid, host_req_valid} >> ptr_q);
    off = '0;
    for (int k = N - 1; k >= 0; k--) if (rot[k]) off = IW'(k);
    sum = {1'b0, ptr_q} + {1'b0, off};
    win = lock_q ? lidx_q : (sum >= (IW+1)'(N) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0]);
    win_rd = !umi_write(pkt[win][UMI_CMD_LSB +: UMI_OPC_W]);
    udev_req_valid = nreset && host_req_valid[win] && !(win_rd && full);
    udev_req_packet = pkt[win];
    hs = udev_req_valid && udev_req_ready;
    host_req_ready = hs ? N'(1) << win : '0;
    push = hs && win_rd;
    host_resp_packet = udev_resp_packet;
    host_resp_valid = (nreset && !empty && udev_resp_valid) ? N'(1) << head : '0;
    udev_resp_ready = !nreset || empty || host_resp_ready[head];
    pop = nreset && !empty && udev_resp_valid && host_resp_ready[head];
    ptr_d = hs ? (win == IW'(N - 1) ? '0 : win + 1'b1) : ptr_q;
    lock_d = udev_req_valid && !udev_req_ready;
    lidx_d = win;
    orphan_d = orphan_q || (empty && udev_resp_valid);
  end
  always_ff @(posedge clk) begin
    if (!nreset) begin
      ptr_q <= '0;
      lock_q <= 1'b0;
      lidx_q <= '0;
      orphan_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      lock_q <= lock_d;
      lidx_q <= lidx_d;
      orphan_q <= orphan_d;
    end
  end
  umi_regif_arb_tagfifo #(.W(IW), .DEPTH(DEPTH)) u_tagfifo (
    .clk(clk),
    .nreset(nreset),
    .push(push),
    .push_data(win),
    .pop(pop),
    .full(full),
    .empty(empty),
    .count(outstanding),
    .head(head)
  );
  assign err_orphan = orphan_q;
endmodule

// File: tb/tb_umi_regif_arb.sv
// tb_umi_regif_arb: directed scenarios plus random traffic checked against a queue-based model of the arbiter
module tb_umi_regif_arb;
  localparam int N = 4, UW = 256, DEPTH = 4, CW = $clog2(DEPTH) + 1;
  typedef logic [$clog2(N)-1:0] idx_t;
  localparam logic [7:0] RD = 8'h01, WR = 8'h03, PW = 8'h05;
  logic clk = 1'b0, nreset = 1'b0;
  logic [N-1:0] host_req_valid, host_req_ready, host_resp_valid, host_resp_ready;
  logic [N*UW-1:0] host_req_packet;
  logic [UW-1:0] host_resp_packet, udev_req_packet, udev_resp_packet;
  logic udev_req_valid, udev_req_ready, udev_resp_valid, udev_resp_ready, err_orphan;
  logic [CW-1:0] outstanding;
  logic [UW-1:0] pk [N];
  int checks = 0, failures = 0;
  idx_t m_ptr = '0, m_lidx = '0, e_w;
  bit m_lock = 0, m_orph = 0, e_rd, e_rv, e_hs, e_pop;
  idx_t q[$];
  always #5 clk = ~clk;
  for (genvar i = 0; i < N; i++) begin : g_pk
    assign host_req_packet[i*UW +: UW] = pk[i];
  end
  umi_regif_arb #(.N(N), .UW(UW), .DEPTH(DEPTH)) dut (
    .clk(clk), .nreset(nreset),
    .host_req_valid(host_req_valid), .host_req_packet(host_req_packet), .host_req_ready(host_req_ready),
    .host_resp_valid(host_resp_valid), .host_resp_packet(host_resp_packet), .host_resp_ready(host_resp_ready),
    .udev_req_valid(udev_req_valid), .udev_req_packet(udev_req_packet), .udev_req_ready(udev_req_ready),
    .udev_resp_valid(udev_resp_valid), .udev_resp_packet(udev_resp_packet), .udev_resp_ready(udev_resp_ready),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );
  function automatic logic [UW-1:0] mk(input logic [7:0] cmd);
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), 24'($urandom()), cmd};
  endfunction
  task automatic chk(input string nm, input logic [UW-1:0] act, input logic [UW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic model_check();
    logic [N-1:0] hrr, hv;
    logic urr;
    bit found = 0;
    e_w = m_lock ? m_lidx : m_ptr;
    if (!m_lock)
      for (int k = 0; k < N; k++) begin
        idx_t j = idx_t'((int'(m_ptr) + k) % N);
        if (!found && host_req_valid[j]) begin
          found = 1;
          e_w = j;
        end
      end
    e_rd = pk[e_w][7:0] == RD;
    e_rv = nreset && host_req_valid[e_w] && !(e_rd && q.size() == DEPTH);
    e_hs = e_rv && udev_req_ready;
    hrr = e_hs ? N'(1) << e_w : '0;
    e_pop = nreset && q.size() > 0 && udev_resp_valid && host_resp_ready[q[0]];
    hv = (nreset && q.size() > 0 && udev_resp_valid) ? N'(1) << q[0] : '0;
    urr = !nreset || q.size() == 0 || host_resp_ready[q[0]];
    chk("udev_req_valid", udev_req_valid, e_rv);
    if (e_rv) chk("udev_req_packet", udev_req_packet, pk[e_w]);
    chk("host_req_ready", host_req_ready, hrr);
    chk("host_resp_valid", host_resp_valid, hv);
    if (hv != 0) chk("host_resp_packet", host_resp_packet, udev_resp_packet);
    chk("udev_resp_ready", udev_resp_ready, urr);
    chk("outstanding", outstanding, q.size());
    chk("err_orphan", err_orphan, m_orph);
  endtask
  task automatic model_update();
    if (!nreset) begin
      m_ptr = '0;
      m_lock = 0;
      q.delete();
      m_orph = 0;
    end else begin
      if (q.size() == 0 && udev_resp_valid) m_orph = 1;
      if (e_pop) void'(q.pop_front());
      if (e_hs) begin
        m_ptr = idx_t'((int'(e_w) + 1) % N);
        if (e_rd) q.push_back(e_w);
      end
      m_lock = e_rv && !udev_req_ready;
      if (m_lock) m_lidx = e_w;
    end
  endtask
  task automatic cyc();
    #1 model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask
  task automatic idle();
    host_req_valid = '0;
    udev_req_ready = 1'b0;
    udev_resp_valid = 1'b0;
    host_resp_ready = '0;
  endtask
  initial begin
    logic [N-1:0] g029 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [UW-1:0] p2;
    idle();
    for (int i = 0; i < N; i++) pk[i] = mk(WR);
    udev_resp_packet = mk(8'h00);
    @(posedge clk);
    @(negedge clk);
    cyc();
    host_req_valid = '1;
    udev_req_ready = 1'b1;
    #1 chk("rst_req_valid", udev_req_valid, 0);
    chk("rst_resp_ready", udev_resp_ready, 1);
    chk("rst_outstanding", outstanding, 0);
    cyc();
    nreset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("rr_grant", host_req_ready, g029[i]);
      cyc();
    end
    host_req_valid = 4'b0100;
    pk[2] = mk(RD);
    p2 = pk[2];
    udev_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        host_req_valid[0] = 1'b1;
        pk[0] = mk(WR);
      end
      #1 chk("lock_ready", host_req_ready, 0);
      chk("lock_valid", udev_req_valid, 1);
      chk("lock_packet", udev_req_packet, p2);
      cyc();
    end
    udev_req_ready = 1'b1;
    #1 chk("lock_grant2", host_req_ready, 4'b0100);
    cyc();
    host_req_valid[2] = 1'b0;
    #1 chk("lock_next0", host_req_ready, 4'b0001);
    cyc();
    host_req_valid = '0;
    udev_resp_valid = 1'b1;
    host_resp_ready = '1;
    #1 chk("resp_to2", host_resp_valid, 4'b0100);
    cyc();
    udev_resp_valid = 1'b0;
    host_req_valid = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      pk[1] = mk(RD);
      #1 chk("fill_grant", host_req_ready, 4'b0010);
      cyc();
    end
    #1 chk("full_cnt", outstanding, 4);
    chk("full_stall", udev_req_valid, 0);
    cyc();
    udev_resp_valid = 1'b1;
    #1 chk("full_pop_stall", udev_req_valid, 0);
    chk("full_pop_resp", host_resp_valid, 4'b0010);
    cyc();
    udev_resp_valid = 1'b0;
    #1 chk("fifth_grant", host_req_ready, 4'b0010);
    cyc();
    host_req_valid = '0;
    #1 chk("fifth_cnt", outstanding, 4);
    udev_resp_valid = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    idle();
    udev_req_ready = 1'b1;
    host_req_valid = 4'b1000;
    pk[3] = mk(RD);
    cyc();
    host_req_valid = 4'b0010;
    pk[1] = mk(RD);
    cyc();
    host_req_valid = '0;
    udev_resp_valid = 1'b1;
    host_resp_ready = 4'b0111;
    #1 chk("order_first", host_resp_valid, 4'b1000);
    chk("order_stall", udev_resp_ready, 0);
    cyc();
    cyc();
    host_resp_ready = '1;
    cyc();
    #1 chk("order_second", host_resp_valid, 4'b0010);
    cyc();
    host_resp_ready = '0;
    #1 chk("orph_ready", udev_resp_ready, 1);
    chk("orph_novalid", host_resp_valid, 0);
    chk("orph_before", err_orphan, 0);
    cyc();
    udev_resp_valid = 1'b0;
    cyc();
    cyc();
    #1 chk("orph_sticky", err_orphan, 1);
    host_req_valid = 4'b0001;
    pk[0] = mk(RD);
    cyc();
    pk[0] = mk(RD);
    cyc();
    host_req_valid = '0;
    #1 chk("pre_rst_cnt", outstanding, 2);
    nreset = 1'b0;
    cyc();
    nreset = 1'b1;
    #1 chk("post_rst_cnt", outstanding, 0);
    chk("post_rst_orph", err_orphan, 0);
    host_req_valid = '1;
    for (int i = 0; i < N; i++) pk[i] = mk(WR);
    #1 chk("post_rst_ptr", host_req_ready, 4'b0001);
    cyc();
    host_req_valid = '0;
    udev_resp_valid = 1'b1;
    #1 chk("post_rst_resp", host_resp_valid, 0);
    cyc();
    udev_resp_valid = 1'b0;
    #1 chk("post_rst_orphan", err_orphan, 1);
    for (int c = 0; c < 3000; c++) begin
      nreset = $urandom_range(0, 299) != 0;
      for (int i = 0; i < N; i++)
        if (m_lock && int'(m_lidx) == i) host_req_valid[i] = 1'b1;
        else begin
          host_req_valid[i] = 1'($urandom_range(0, 1));
          pk[i] = mk($urandom_range(0, 3) < 2 ? RD : ($urandom_range(0, 1) != 0 ? WR : PW));
        end
      udev_req_ready = $urandom_range(0, 2) != 0;
      udev_resp_valid = 1'($urandom_range(0, 1));
      host_resp_ready = N'($urandom());
      udev_resp_packet = mk(8'($urandom()));
      cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
